// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle integer ops plus an iterative restoring divider,
// with valid/ready handshakes on both the request and the result side.
module alu_multicycle #(
  parameter int XLEN = 32,
  parameter int OPW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] ip1,
  input  logic [XLEN-1:0] ip2,
  input  logic [OPW-1:0]  operation,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero_flag,
  output logic            busy
);

  localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
  localparam logic [OPW-1:0] OP_SLL  = OPW'(2);
  localparam logic [OPW-1:0] OP_SRL  = OPW'(3);
  localparam logic [OPW-1:0] OP_SRA  = OPW'(4);
  localparam logic [OPW-1:0] OP_SLT  = OPW'(5);
  localparam logic [OPW-1:0] OP_SLTU = OPW'(6);
  localparam logic [OPW-1:0] OP_AND  = OPW'(7);
  localparam logic [OPW-1:0] OP_OR   = OPW'(8);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(9);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(10);
  localparam logic [OPW-1:0] OP_DIVU = OPW'(11);
  localparam logic [OPW-1:0] OP_REM  = OPW'(12);
  localparam logic [OPW-1:0] OP_REMU = OPW'(13);

  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

  state_t          state;
  logic [SHW-1:0]  count;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] divisor;
  logic            div_is_rem;
  logic            neg_q;
  logic            neg_r;

  logic [SHW-1:0]  shamt;
  logic            is_div_class;
  logic            is_signed_div;
  logic            is_rem_op;
  logic            div_by_zero;
  logic            signed_ovf;
  logic            start_divide;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;
  logic [XLEN-1:0] fast_res;
  logic [XLEN:0]   partial;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic [XLEN-1:0] div_res;

  assign shamt         = ip2[SHW-1:0];
  assign is_signed_div = (operation == OP_DIV) || (operation == OP_REM);
  assign is_rem_op     = (operation == OP_REM) || (operation == OP_REMU);
  assign is_div_class  = is_signed_div || is_rem_op || (operation == OP_DIVU);
  assign div_by_zero   = (ip2 == '0);
  assign signed_ovf    = is_signed_div && (ip1 == MOST_NEG) && (ip2 == '1);
  assign start_divide  = is_div_class && !div_by_zero && !signed_ovf;
  assign mag1          = (is_signed_div && ip1[XLEN-1]) ? -ip1 : ip1;
  assign mag2          = (is_signed_div && ip2[XLEN-1]) ? -ip2 : ip2;

  assign in_ready = !rst && (state == IDLE) && (!out_valid || out_ready);

  // Divide-class entries here only cover the zero-divisor and overflow shortcuts
  always_comb begin
    fast_res = '0;
    case (operation)
      OP_ADD:          fast_res = ip1 + ip2;
      OP_SUB:          fast_res = ip1 - ip2;
      OP_SLL:          fast_res = ip1 << shamt;
      OP_SRL:          fast_res = ip1 >> shamt;
      OP_SRA:          fast_res = $unsigned($signed(ip1) >>> shamt);
      OP_SLT:          fast_res = {{(XLEN-1){1'b0}}, $signed(ip1) < $signed(ip2)};
      OP_SLTU:         fast_res = {{(XLEN-1){1'b0}}, ip1 < ip2};
      OP_AND:          fast_res = ip1 & ip2;
      OP_OR:           fast_res = ip1 | ip2;
      OP_XOR:          fast_res = ip1 ^ ip2;
      OP_DIV, OP_DIVU: fast_res = div_by_zero ? '1 : ip1;
      OP_REM, OP_REMU: fast_res = div_by_zero ? ip1 : '0;
      default:         fast_res = '0;
    endcase
  end

  // The remainder stays below the divisor, so one extra bit holds the borrow
  assign partial = {rem, quo[XLEN-1]};
  assign trial   = partial - {1'b0, divisor};
  assign q_fix   = neg_q ? -quo : quo;
  assign r_fix   = neg_r ? -rem : rem;
  assign div_res = div_is_rem ? r_fix : q_fix;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      result     <= '0;
      zero_flag  <= 1'b1;
      count      <= '0;
      quo        <= '0;
      rem        <= '0;
      divisor    <= '0;
      div_is_rem <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            if (start_divide) begin
              state      <= DIVIDE;
              busy       <= 1'b1;
              count      <= '0;
              quo        <= mag1;
              rem        <= '0;
              divisor    <= mag2;
              div_is_rem <= is_rem_op;
              neg_q      <= is_signed_div && (ip1[XLEN-1] ^ ip2[XLEN-1]);
              neg_r      <= is_signed_div && ip1[XLEN-1];
            end else begin
              result    <= fast_res;
              zero_flag <= (fast_res == '0);
              out_valid <= 1'b1;
            end
          end
        end
        DIVIDE: begin
          if (!trial[XLEN]) begin
            rem <= trial[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b1};
          end else begin
            rem <= partial[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b0};
          end
          count <= count + SHW'(1);
          if (count == SHW'(XLEN-1)) begin
            state <= DONE;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          // Wait here until the previous result has been taken
          if (!out_valid || out_ready) begin
            result    <= div_res;
            zero_flag <= (div_res == '0);
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: directed vectors on a 32-bit instance, then a random
// back-pressured stream on 32- and 64-bit instances checked against an arithmetic model.
module tb_alu_multicycle;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_SLL  = 5'd2;
  localparam logic [4:0] OP_SRL  = 5'd3;
  localparam logic [4:0] OP_SRA  = 5'd4;
  localparam logic [4:0] OP_SLT  = 5'd5;
  localparam logic [4:0] OP_SLTU = 5'd6;
  localparam logic [4:0] OP_AND  = 5'd7;
  localparam logic [4:0] OP_OR   = 5'd8;
  localparam logic [4:0] OP_XOR  = 5'd9;
  localparam logic [4:0] OP_DIV  = 5'd10;
  localparam logic [4:0] OP_DIVU = 5'd11;
  localparam logic [4:0] OP_REM  = 5'd12;
  localparam logic [4:0] OP_REMU = 5'd13;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  in_valid_v;
  logic [1:0]  out_ready_v;
  logic [63:0] ip1_a [2];
  logic [63:0] ip2_a [2];
  logic [4:0]  op_a  [2];
  wire  [1:0]  in_ready_v;
  wire  [1:0]  out_valid_v;
  wire  [1:0]  zf_v;
  wire  [1:0]  busy_v;
  wire  [31:0] res32;
  wire  [63:0] res64;

  int checks = 0;
  int errors = 0;
  int busy_cnt;
  int ready_cnt;

  always #5 clk = ~clk;

  alu_multicycle #(.XLEN(32), .OPW(5)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .ip1(ip1_a[0][31:0]), .ip2(ip2_a[0][31:0]), .operation(op_a[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .result(res32), .zero_flag(zf_v[0]), .busy(busy_v[0])
  );

  alu_multicycle #(.XLEN(64), .OPW(5)) dut64 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .ip1(ip1_a[1]), .ip2(ip2_a[1]), .operation(op_a[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .result(res64), .zero_flag(zf_v[1]), .busy(busy_v[1])
  );

  function automatic logic [63:0] res_of(input int g);
    return (g == 0) ? {32'h0, res32} : res64;
  endfunction

  // Reference behaviour expressed with plain integer arithmetic at width w
  function automatic logic [63:0] model(input int w, input logic [4:0] op,
                                        input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0] mask, a, b, mn;
    longint sa, sb;
    int sh;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    mn   = (w == 64) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
    a = a_in & mask;
    b = b_in & mask;
    sa = (w == 64) ? longint'(a) : longint'({{32{a[31]}}, a[31:0]});
    sb = (w == 64) ? longint'(b) : longint'({{32{b[31]}}, b[31:0]});
    sh = int'(b[5:0]) & (w - 1);
    case (op)
      OP_ADD:  return (a + b) & mask;
      OP_SUB:  return (a - b) & mask;
      OP_SLL:  return (a << sh) & mask;
      OP_SRL:  return a >> sh;
      OP_SRA:  return 64'(sa >>> sh) & mask;
      OP_SLT:  return (sa < sb) ? 64'd1 : 64'd0;
      OP_SLTU: return (a < b) ? 64'd1 : 64'd0;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_DIV: begin
        if (b == 0) return mask;
        if (a == mn && b == mask) return a;
        return 64'(sa / sb) & mask;
      end
      OP_DIVU: return (b == 0) ? mask : a / b;
      OP_REM: begin
        if (b == 0) return a;
        if (a == mn && b == mask) return 64'd0;
        return 64'(sa % sb) & mask;
      end
      OP_REMU: return (b == 0) ? a : a % b;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] rand_operand(input int w);
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0:       v = 64'd0;
      1:       v = 64'hFFFF_FFFF_FFFF_FFFF;
      2:       v = (w == 64) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
      3:       v = 64'($urandom_range(0, 20));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // One scoreboard per instance: every valid output must match the oldest accepted request
  for (genvar g = 0; g < 2; g++) begin : chk
    localparam int W = (g == 0) ? 32 : 64;
    logic [63:0] exp_q [$];
    always @(negedge clk) begin
      if (rst) begin
        exp_q.delete();
      end else begin
        if (out_valid_v[g]) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL stream%0d_extra: got result %h with no request outstanding", W, res_of(g));
          end else if (res_of(g) !== exp_q[0] || zf_v[g] !== (exp_q[0] == 64'd0)) begin
            errors++;
            $display("[TB] FAIL stream%0d_result: got %h zf %b, expected %h zf %b",
                     W, res_of(g), zf_v[g], exp_q[0], exp_q[0] == 64'd0);
          end
          if (out_ready_v[g] && exp_q.size() != 0) void'(exp_q.pop_front());
        end
        if (in_valid_v[g] && in_ready_v[g])
          exp_q.push_back(model(W, op_a[g], ip1_a[g], ip2_a[g]));
      end
    end
  end

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
    int tries = 0;
    op_a[0] = op;
    ip1_a[0] = a;
    ip2_a[0] = b;
    in_valid_v[0] = 1'b1;
    @(negedge clk);
    while (!in_ready_v[0] && tries < 300) begin
      @(negedge clk);
      tries++;
    end
    if (!in_ready_v[0]) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got in_ready 0 for op %0d, expected 1", op);
    end
    @(posedge clk);
    #1;
    in_valid_v[0] = 1'b0;
  endtask

  // Called right after the accepting edge; latency counts that edge as cycle 1
  task automatic check_output(input string name, input logic [63:0] exp, input logic exp_zf,
                              input int exp_lat);
    int lat = 1;
    busy_cnt = 0;
    ready_cnt = 0;
    while (!out_valid_v[0] && lat < 300) begin
      busy_cnt += int'(busy_v[0]);
      ready_cnt += int'(in_ready_v[0]);
      @(posedge clk);
      #1;
      lat++;
    end
    check_val({name, "_valid"}, {63'd0, out_valid_v[0]}, 64'd1);
    check_val({name, "_result"}, res_of(0), exp);
    check_val({name, "_zf"}, {63'd0, zf_v[0]}, {63'd0, exp_zf});
    if (exp_lat > 0) check_val({name, "_latency"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic random_stream(input int g, input int n);
    int sent = 0;
    int cyc = 0;
    bit acc;
    int w = (g == 0) ? 32 : 64;
    in_valid_v[g] = 1'b0;
    while (sent < n && cyc < 40000) begin
      @(negedge clk);
      acc = in_valid_v[g] && in_ready_v[g];
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        sent++;
        in_valid_v[g] = 1'b0;
      end
      if (!in_valid_v[g] && sent < n && $urandom_range(0, 3) != 0) begin
        op_a[g] = 5'($urandom_range(0, 15));
        ip1_a[g] = rand_operand(w);
        ip2_a[g] = rand_operand(w);
        in_valid_v[g] = 1'b1;
      end
      out_ready_v[g] = ($urandom_range(0, 3) != 0);
    end
    if (sent < n) begin
      checks++;
      errors++;
      $display("[TB] FAIL stream%0d_timeout: got %0d accepted, expected %0d", w, sent, n);
    end
    in_valid_v[g] = 1'b0;
    out_ready_v[g] = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid_v = 2'b00;
    out_ready_v = 2'b11;
    for (int i = 0; i < 2; i++) begin
      ip1_a[i] = 64'd0;
      ip2_a[i] = 64'd0;
      op_a[i] = OP_ADD;
    end
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_out_valid", {63'd0, out_valid_v[0]}, 64'd0);
    check_val("reset_busy", {63'd0, busy_v[0]}, 64'd0);
    check_val("reset_result", res_of(0), 64'd0);
    check_val("reset_zf", {63'd0, zf_v[0]}, 64'd1);
    check_val("reset_in_ready", {63'd0, in_ready_v[0]}, 64'd0);
    rst = 1'b0;
    #1;
    check_val("release_in_ready", {63'd0, in_ready_v[0]}, 64'd1);

    check_val("model_rem_neg", model(32, OP_REM, 64'hFFFF_FFF9, 64'd2), 64'hFFFF_FFFF);
    check_val("model_div_ovf64", model(64, OP_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF),
              64'h8000_0000_0000_0000);
    check_val("model_sra", model(32, OP_SRA, 64'h8000_0000, 64'd4), 64'hF800_0000);

    apply_stimulus(OP_ADD, 64'd23, 64'd46);   check_output("add", 64'd69, 1'b0, 1);
    apply_stimulus(OP_SUB, 64'd128, 64'd59);  check_output("sub", 64'd69, 1'b0, 1);
    apply_stimulus(OP_SLL, 64'd23, 64'd2);    check_output("sll", 64'd92, 1'b0, 1);
    apply_stimulus(OP_XOR, 64'd1, 64'd1);     check_output("xor", 64'd0, 1'b1, 1);
    apply_stimulus(OP_SLT, 64'hFFFF_FFFF, 64'd1);  check_output("slt", 64'd1, 1'b0, 1);
    apply_stimulus(OP_SLTU, 64'hFFFF_FFFF, 64'd1); check_output("sltu", 64'd0, 1'b1, 1);
    apply_stimulus(OP_SRA, 64'h8000_0000, 64'd36); check_output("sra", 64'hF800_0000, 1'b0, 1);
    apply_stimulus(OP_SRL, 64'h8000_0000, 64'd4);  check_output("srl", 64'h0800_0000, 1'b0, 1);
    apply_stimulus(5'd31, 64'd5, 64'd5);      check_output("badop", 64'd0, 1'b1, 1);

    apply_stimulus(OP_REMU, 64'd654, 64'd46);
    check_output("remu", 64'd10, 1'b0, 34);
    check_val("remu_busy_cycles", 64'(busy_cnt), 64'd32);
    check_val("remu_in_ready_cycles", 64'(ready_cnt), 64'd0);
    apply_stimulus(OP_DIV, 64'hFFFF_FFF9, 64'd2);  check_output("div_neg", 64'hFFFF_FFFD, 1'b0, 34);
    apply_stimulus(OP_REM, 64'hFFFF_FFF9, 64'd2);  check_output("rem_neg", 64'hFFFF_FFFF, 1'b0, 34);
    apply_stimulus(OP_DIVU, 64'd12345, 64'd0);     check_output("divu_zero", 64'hFFFF_FFFF, 1'b0, 1);
    apply_stimulus(OP_REM, 64'd5, 64'd0);          check_output("rem_zero", 64'd5, 1'b0, 1);
    apply_stimulus(OP_DIV, 64'h8000_0000, 64'hFFFF_FFFF); check_output("div_ovf", 64'h8000_0000, 1'b0, 1);
    apply_stimulus(OP_REM, 64'h8000_0000, 64'hFFFF_FFFF); check_output("rem_ovf", 64'd0, 1'b1, 1);

    // Back-pressure: hold the result, keep a second request waiting, then release
    @(posedge clk);
    #1;
    out_ready_v[0] = 1'b0;
    apply_stimulus(OP_ADD, 64'd5, 64'd6);
    op_a[0] = OP_ADD;
    ip1_a[0] = 64'd10;
    ip2_a[0] = 64'd20;
    in_valid_v[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("hold_valid", {63'd0, out_valid_v[0]}, 64'd1);
      check_val("hold_result", res_of(0), 64'd11);
      check_val("hold_in_ready", {63'd0, in_ready_v[0]}, 64'd0);
    end
    out_ready_v[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_v[0] = 1'b0;
    check_val("queued_valid", {63'd0, out_valid_v[0]}, 64'd1);
    check_val("queued_result", res_of(0), 64'd30);

    // Reset in the middle of a divide discards it
    @(posedge clk);
    #1;
    apply_stimulus(OP_DIVU, 64'd1000, 64'd7);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("abort_out_valid", {63'd0, out_valid_v[0]}, 64'd0);
    check_val("abort_busy", {63'd0, busy_v[0]}, 64'd0);
    check_val("abort_result", res_of(0), 64'd0);
    check_val("abort_in_ready", {63'd0, in_ready_v[0]}, 64'd0);
    rst = 1'b0;
    #1;
    check_val("abort_release_ready", {63'd0, in_ready_v[0]}, 64'd1);
    apply_stimulus(OP_ADD, 64'd1, 64'd1);
    check_output("after_abort_add", 64'd2, 1'b0, 1);
    repeat (60) @(posedge clk);
    #1;

    fork
      random_stream(0, 200);
      random_stream(1, 150);
    join

    repeat (150) @(posedge clk);
    #1;
    check_val("drain32", 64'(chk[0].exp_q.size()), 64'd0);
    check_val("drain64", 64'(chk[1].exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
